mem_stage_ctrl: RTL and testbench

- Consumer side of the EX/MEM pipeline register: the MEM stage.
- Takes the registered EX/MEM fields: WB/M control, ALU result as address, store data, and destination register.
- Runs a req/ack access to a variable-latency data memory and stalls the upstream pipeline while the access is outstanding.
- Produces the MEM/WB register contents, inserting bubbles while stalled.

---
 rtl/mem_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs req/ack data-memory accesses and fills the MEM/WB register.
// Latency: MEM/WB outputs 1 cycle after the instruction leaves EX/MEM; a zero-wait ack adds no stall.
// Backpressure: stall_o (combinational) holds IF/ID/EX and EX/MEM while an access is outstanding.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   WB_i, M_i           EX/MEM control (M_i[1] = MemRead, M_i[0] = MemWrite)
//   addr_i, data_i, rd_i  ALU result / address, store data, destination register
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_ack_i, mem_rdata_i  data-memory port
//   stall_o             upstream hold
//   WB_o, rd_o, alu_o, rdata_o  MEM/WB register
//   err_o               sticky timeout flag; only reset clears it
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic [1:0]  M_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [1:0]  WB_o,
    output logic [4:0]  rd_o,
    output logic [31:0] alu_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0] state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       access;
    logic       pure_load;

    assign access    = M_i[1] | M_i[0];
    // When both MemRead and MemWrite are set the write wins, so only a pure read returns data.
    assign pure_load = M_i[1] & ~M_i[0];

    assign mem_we_o    = M_i[0];
    assign mem_addr_o  = addr_i;
    assign mem_wdata_o = data_i;
    assign err_o       = (state == ST_ERR);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_req_o = 1'b0;
        stall_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                // Ack in the same cycle as the request completes without leaving IDLE.
                mem_req_o = access;
                stall_o   = access & ~mem_ack_i;
                if (access && !mem_ack_i) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = 8'd1;
                end
            end
            ST_WAIT: begin
                mem_req_o = 1'b1;
                stall_o   = ~mem_ack_i;
                if (mem_ack_i) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 8'd0;
                end else if (cnt == TIMEOUT_CNT) begin
                    // cnt counts WAIT cycles already spent; it saturates here, so never wraps.
                    state_nxt = ST_ERR;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_ERR: begin
                // Dead end: the pipeline stays frozen until reset.
                stall_o = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // MEM/WB register: a stalled cycle writes a bubble so nothing is retired twice.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            WB_o    <= 2'd0;
            rd_o    <= 5'd0;
            alu_o   <= 32'd0;
            rdata_o <= 32'd0;
        end else if (stall_o) begin
            WB_o    <= 2'd0;
            rd_o    <= 5'd0;
            alu_o   <= 32'd0;
            rdata_o <= 32'd0;
        end else begin
            WB_o    <= WB_i;
            rd_o    <= rd_i;
            alu_o   <= addr_i;
            rdata_o <= pure_load ? mem_rdata_i : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    typedef struct packed {
        logic [1:0]  wb;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
    } memwb_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  WB_i;
    logic [1:0]  M_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [4:0]  rd_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic [1:0]  WB_o;
    logic [4:0]  rd_o;
    logic [31:0] alu_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int n_assert = 0;
    int n_fail   = 0;
    memwb_t exp_q[$];

    mem_stage_ctrl #(.TIMEOUT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .WB_i        (WB_i),
        .M_i         (M_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .rd_i        (rd_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .WB_o        (WB_o),
        .rd_o        (rd_o),
        .alu_o       (alu_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, ".WB_o"},    {30'd0, WB_o}, 32'd0);
        chk({tag, ".rd_o"},    {27'd0, rd_o}, 32'd0);
        chk({tag, ".alu_o"},   alu_o,         32'd0);
        chk({tag, ".rdata_o"}, rdata_o,       32'd0);
    endtask

    // One clock cycle: drive EX/MEM + memory response, check the combinational
    // outputs before the edge, predict MEM/WB, then compare it after the edge.
    task automatic step(input string tag,
                        input logic [1:0] m, input logic [1:0] wb, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd,
                        input logic ack, input logic [31:0] rdata,
                        input logic e_req, input logic e_stall, input logic e_err);
        memwb_t e;
        memwb_t got;
        M_i = m; WB_i = wb; addr_i = addr; data_i = data; rd_i = rd;
        mem_ack_i = ack; mem_rdata_i = rdata;
        #1;
        chk({tag, ".req"},   {31'd0, mem_req_o}, {31'd0, e_req});
        chk({tag, ".stall"}, {31'd0, stall_o},   {31'd0, e_stall});
        chk({tag, ".err"},   {31'd0, err_o},     {31'd0, e_err});
        if (e_req) begin
            chk({tag, ".we"},    {31'd0, mem_we_o}, {31'd0, m[0]});
            chk({tag, ".addr"},  mem_addr_o,  addr);
            chk({tag, ".wdata"}, mem_wdata_o, data);
        end
        if (e_stall) e = '0;
        else e = '{wb: wb, rd: rd, alu: addr, rdata: (m == 2'b10) ? rdata : 32'd0};
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        e   = exp_q.pop_front();
        got = '{wb: WB_o, rd: rd_o, alu: alu_o, rdata: rdata_o};
        chk({tag, ".WB_o"},    {30'd0, got.wb}, {30'd0, e.wb});
        chk({tag, ".rd_o"},    {27'd0, got.rd}, {27'd0, e.rd});
        chk({tag, ".alu_o"},   got.alu,         e.alu);
        chk({tag, ".rdata_o"}, got.rdata,       e.rdata);
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        M_i = 2'b00; WB_i = 2'b00; addr_i = 32'd0; data_i = 32'd0; rd_i = 5'd0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    endtask

    initial begin
        rst_i = 1'b0;
        idle_inputs();
        #2;
        chk("reset.req",   {31'd0, mem_req_o}, 32'd0);
        chk("reset.stall", {31'd0, stall_o},   32'd0);
        chk("reset.err",   {31'd0, err_o},     32'd0);
        chk_regs_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        // ALU op, then a spurious ack with no access outstanding
        step("alu",     2'b00, 2'b10, 32'h10, 32'h0, 5'd5, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
        step("spur",    2'b00, 2'b01, 32'h14, 32'h0, 5'd6, 1'b1, 32'h77777777, 1'b0, 1'b0, 1'b0);
        // Load acked in the request cycle: no stall
        step("ld0",     2'b10, 2'b01, 32'h20, 32'h0, 5'd7, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        // Store acked on the 3rd WAIT cycle
        step("st.c0",   2'b01, 2'b00, 32'h40, 32'h1234, 5'd3, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step("st.w1",   2'b01, 2'b00, 32'h40, 32'h1234, 5'd3, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step("st.w2",   2'b01, 2'b00, 32'h40, 32'h1234, 5'd3, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step("st.w3",   2'b01, 2'b00, 32'h40, 32'h1234, 5'd3, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        // Read+write together: write wins, no load data captured
        step("rw",      2'b11, 2'b11, 32'h44, 32'h55AA, 5'd8, 1'b1, 32'hFFFF0000, 1'b1, 1'b0, 1'b0);
        // Back-to-back loads, one wait cycle each, request never drops
        step("bb.a0",   2'b10, 2'b01, 32'h100, 32'h0, 5'd1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0);
        step("bb.a1",   2'b10, 2'b01, 32'h100, 32'h0, 5'd1, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
        step("bb.b0",   2'b10, 2'b01, 32'h104, 32'h0, 5'd2, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0);
        step("bb.b1",   2'b10, 2'b01, 32'h104, 32'h0, 5'd2, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset with a non-zero MEM/WB register
        #2;
        rst_i = 1'b0;
        idle_inputs();
        #1;
        chk_regs_zero("arst");
        @(negedge clk_i);
        rst_i = 1'b1;

        // Reset in the middle of WAIT abandons the access
        step("rw.c0",   2'b10, 2'b01, 32'h200, 32'h0, 5'd4, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step("rw.w1",   2'b10, 2'b01, 32'h200, 32'h0, 5'd4, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        #2;
        rst_i = 1'b0;
        idle_inputs();
        #1;
        chk("midwait.req",   {31'd0, mem_req_o}, 32'd0);
        chk("midwait.stall", {31'd0, stall_o},   32'd0);
        chk("midwait.err",   {31'd0, err_o},     32'd0);
        chk_regs_zero("midwait");
        @(negedge clk_i);
        rst_i = 1'b1;
        step("fresh",   2'b10, 2'b10, 32'h300, 32'h0, 5'd9, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);

        // Timeout with TIMEOUT=4: request cycle plus 4 WAIT cycles, then ERR
        step("to.c0",   2'b10, 2'b01, 32'h400, 32'h0, 5'd10, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step("to.w1",   2'b10, 2'b01, 32'h400, 32'h0, 5'd10, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step("to.w2",   2'b10, 2'b01, 32'h400, 32'h0, 5'd10, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step("to.w3",   2'b10, 2'b01, 32'h400, 32'h0, 5'd10, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step("to.w4",   2'b10, 2'b01, 32'h400, 32'h0, 5'd10, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step("to.err0", 2'b10, 2'b01, 32'h400, 32'h0, 5'd10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        // A late ack does not revive the block
        step("to.err1", 2'b10, 2'b01, 32'h400, 32'h0, 5'd10, 1'b1, 32'h1, 1'b0, 1'b1, 1'b1);
        #2;
        rst_i = 1'b0;
        idle_inputs();
        #1;
        chk("to.rst.req",   {31'd0, mem_req_o}, 32'd0);
        chk("to.rst.stall", {31'd0, stall_o},   32'd0);
        chk("to.rst.err",   {31'd0, err_o},     32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        step("post",    2'b00, 2'b10, 32'h500, 32'h0, 5'd11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
